// File: rtl/if_stage.sv
// Instruction fetch stage: issues one sram fetch at a time from pf_pc and queues returned words for decode.
// Latency: a word returned with data_ok is presented to decode on the following cycle.
// Backpressure: ds_allowin low fills the fetch buffer, then requests stop (STALL) until it drains.
// Build option IF_PREFETCH_EN: 2-entry buffer so the next fetch overlaps a buffered word; otherwise 1 entry.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

`ifdef IF_PREFETCH_EN
    localparam logic [1:0] DEPTH    = 2'd2;
    localparam logic       PTR_STEP = 1'b1;
`else
    localparam logic [1:0] DEPTH    = 2'd1;
    localparam logic       PTR_STEP = 1'b0;
`endif

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_STALL} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        fsm_req;
    logic        req_en;
    logic [31:0] pf_pc;
    logic [31:0] req_pc;
    logic        cancel;
    logic [31:0] buf_pc   [0:1];
    logic [31:0] buf_inst [0:1];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [1:0]  count_nxt;

    logic        br_taken;
    logic [31:0] br_target;
    logic        addr_fire;
    logic        resp;
    logic        buf_wr;
    logic        buf_pop;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // A response is only meaningful while a request is outstanding (WAIT); a
    // redirect in the same cycle makes it stale, as does a pending cancel.
    assign addr_fire = inst_sram_req && inst_sram_addr_ok;
    assign resp      = (state == S_WAIT) && inst_sram_data_ok;
    assign buf_wr    = resp && !cancel && !br_taken;

    // A redirect hides the head from decode in the same cycle it flushes it.
    assign fs_to_ds_valid = (count != 2'd0) && !br_taken;
    assign buf_pop        = fs_to_ds_valid && ds_allowin;
    assign fs_to_ds_bus   = {buf_pc[rd_ptr], buf_inst[rd_ptr]};

    // req_en keeps the request low until the first clock edge after reset release.
    assign inst_sram_req  = req_en && fsm_req;
    assign inst_sram_addr = pf_pc;

    // Buffer occupancy after this cycle's flush/write/pop.
    always_comb begin
        count_nxt = count;
        if (br_taken) begin
            count_nxt = 2'd0;
        end else begin
            count_nxt = count + {1'b0, buf_wr} - {1'b0, buf_pop};
        end
    end

    // Request FSM next state and request output.
    always_comb begin
        state_nxt = state;
        fsm_req   = 1'b0;
        case (state)
            S_REQ: begin
                fsm_req = 1'b1;
                if (addr_fire) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp) begin
                    state_nxt = (count_nxt < DEPTH) ? S_REQ : S_STALL;
                end
            end
            S_STALL: begin
                if (count_nxt < DEPTH) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // Reset-synchronised request enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_en <= 1'b0;
        end else begin
            req_en <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch pc: a redirect always wins, so pf_pc doubles as the pending-target latch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pf_pc  <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            if (addr_fire) begin
                req_pc <= pf_pc;
            end
            if (br_taken) begin
                pf_pc <= br_target;
            end else if (addr_fire) begin
                pf_pc <= pf_pc + 32'd4;
            end
        end
    end

    // Cancel flag: set when a redirect leaves a request in flight, cleared by its response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cancel <= 1'b0;
        end else if (br_taken) begin
            cancel <= addr_fire || ((state == S_WAIT) && !inst_sram_data_ok);
        end else if (resp) begin
            cancel <= 1'b0;
        end
    end

    // Fetch buffer pointers and occupancy; a redirect empties it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            count <= count_nxt;
            if (br_taken) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (buf_wr) begin
                    wr_ptr <= wr_ptr ^ PTR_STEP;
                end
                if (buf_pop) begin
                    rd_ptr <= rd_ptr ^ PTR_STEP;
                end
            end
        end
    end

    // Fetch buffer storage: each word is tagged with the pc of its request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                buf_pc[i]   <= 32'd0;
                buf_inst[i] <= 32'd0;
            end
        end else if (buf_wr) begin
            buf_pc[wr_ptr]   <= req_pc;
            buf_inst[wr_ptr] <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

`ifdef IF_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        ds_allowin = 1'b0;
    logic [32:0] br_bus = 33'd0;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = 32'd0;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .ds_allowin       (ds_allowin),
        .br_bus           (br_bus),
        .fs_to_ds_valid   (fs_to_ds_valid),
        .fs_to_ds_bus     (fs_to_ds_bus),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata  (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // SRAM slave state and the decode-side model: the delivered stream must be
    // sequential pcs, restarting at the branch target after every redirect.
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] fire_q[$];

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fire;
        logic        del;
        logic        overlap;
        logic [31:0] epc;
    } obs_t;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hc3a5, a[31:16] ^ 16'h1234};
    endfunction

    // One cycle: drive inputs after the falling edge, sample just after, update models.
    task automatic tick(input logic br, input logic [31:0] tgt, input logic aok,
                        input logic dok, input logic allow, output obs_t o);
        @(negedge clk);
        ds_allowin        = allow;
        br_bus            = {br, tgt};
        inst_sram_addr_ok = aok;
        inst_sram_data_ok = dok;
        inst_sram_rdata   = pend ? inst_of(pend_addr) : 32'hdeadbeef;
        #1;
        o.req     = inst_sram_req;
        o.addr    = inst_sram_addr;
        o.vld     = fs_to_ds_valid;
        o.pc      = fs_to_ds_bus[63:32];
        o.inst    = fs_to_ds_bus[31:0];
        o.fire    = inst_sram_req && aok;
        o.del     = fs_to_ds_valid && allow;
        o.overlap = o.fire && pend;
        o.epc     = exp_pc;
        if (dok && pend) pend = 1'b0;
        if (o.fire) begin
            pend      = 1'b1;
            pend_addr = o.addr;
            fire_q.push_back(o.addr);
        end
        if (br) exp_pc = tgt;
        else if (o.del) exp_pc = exp_pc + 32'd4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn            = 1'b0;
        ds_allowin        = 1'b0;
        br_bus            = 33'd0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        pend   = 1'b0;
        exp_pc = RESET_PC;
        fire_q.delete();
    endtask

    task automatic test_reset();
        obs_t o;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", inst_sram_req); end
        checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fs_to_ds_valid); end
        checks++; if (inst_sram_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", inst_sram_addr, RESET_PC); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        pend = 1'b0; exp_pc = RESET_PC; fire_q.delete();
        #1;
        checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL release_req_early: got %b want 0", inst_sram_req); end
        tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, o);
        checks++; if (o.req !== 1'b1 || o.addr !== RESET_PC) begin errors++; $display("FAIL first_req: req=%b addr=%h want 1 %h", o.req, o.addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        obs_t o;
        int   n_del = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            tick(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, o);
            if (o.del) begin
                n_del++;
                checks++; if (o.pc !== o.epc || o.inst !== inst_of(o.epc)) begin errors++; $display("FAIL seq_stream: pc=%h inst=%h want pc=%h inst=%h", o.pc, o.inst, o.epc, inst_of(o.epc)); end
            end
        end
        checks++;
        if (fire_q.size() < 3) begin errors++; $display("FAIL seq_fires: got %0d fires want >=3", fire_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if (fire_q[i] !== RESET_PC + 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, fire_q[i], RESET_PC + 32'(4 * i)); end
        end
        checks++; if (n_del < 5) begin errors++; $display("FAIL seq_count: got %0d deliveries want >=5", n_del); end
    endtask

    task automatic test_redirect_outstanding();
        obs_t o;
        logic found = 1'b0;
        logic got = 1'b0;
        int   k;
        do_reset();
        for (int c = 0; c < 40 && !found; c++) begin
            tick(1'b0, 32'd0, 1'b1, pend, 1'b1, o);
            if (o.del) begin
                checks++; if (o.pc !== o.epc) begin errors++; $display("FAIL redir_pre: pc=%h want %h", o.pc, o.epc); end
            end
            if (o.fire && o.addr == 32'h1c000008) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL redir_setup: fetch of 1c000008 seen=%b want 1", found); end
        k = fire_q.size();
        tick(1'b1, 32'h1c000100, 1'b0, 1'b0, 1'b1, o);
        checks++; if (o.vld !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", o.vld); end
        for (int c = 0; c < 40 && !got; c++) begin
            tick(1'b0, 32'd0, 1'b1, pend, 1'b1, o);
            if (o.del) begin
                got = 1'b1;
                checks++; if (o.pc !== 32'h1c000100 || o.inst !== inst_of(32'h1c000100)) begin errors++; $display("FAIL redir_target: pc=%h inst=%h want 1c000100 %h", o.pc, o.inst, inst_of(32'h1c000100)); end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL redir_timeout: delivered=%b want 1", got); end
        checks++; if (fire_q.size() <= k || fire_q[k] !== 32'h1c000100) begin errors++; $display("FAIL redir_fetch: fires=%0d want next fetch 1c000100", fire_q.size()); end
    endtask

    task automatic test_stall();
        obs_t o;
        int   n_del = 0;
        do_reset();
        for (int c = 0; c < 6; c++) tick(1'b0, 32'd0, 1'b1, pend, 1'b0, o);
        checks++; if (fire_q.size() !== DEPTH) begin errors++; $display("FAIL stall_fills: got %0d fetches want %0d", fire_q.size(), DEPTH); end
        checks++; if (o.req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", o.req); end
        checks++; if (o.vld !== 1'b1) begin errors++; $display("FAIL stall_head: got %b want 1", o.vld); end
        for (int c = 0; c < 40 && n_del < DEPTH + 2; c++) begin
            tick(1'b0, 32'd0, 1'b1, pend, 1'b1, o);
            if (o.del) begin
                n_del++;
                checks++; if (o.pc !== o.epc || o.inst !== inst_of(o.epc)) begin errors++; $display("FAIL stall_stream: pc=%h want %h", o.pc, o.epc); end
            end
        end
        checks++; if (n_del !== DEPTH + 2) begin errors++; $display("FAIL stall_release: got %0d deliveries want %0d", n_del, DEPTH + 2); end
    endtask

    task automatic test_br_flush();
        obs_t o;
        logic got = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) tick(1'b0, 32'd0, 1'b1, pend, 1'b0, o);
        checks++; if (o.vld !== 1'b1) begin errors++; $display("FAIL flush_setup: head valid=%b want 1", o.vld); end
        tick(1'b1, 32'h1c000300, 1'b0, 1'b0, 1'b1, o);
        checks++; if (o.vld !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", o.vld); end
        for (int c = 0; c < 40 && !got; c++) begin
            tick(1'b0, 32'd0, 1'b1, pend, 1'b1, o);
            if (o.del) begin
                got = 1'b1;
                checks++; if (o.pc !== 32'h1c000300 || o.inst !== inst_of(32'h1c000300)) begin errors++; $display("FAIL flush_next: pc=%h want 1c000300", o.pc); end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL flush_timeout: delivered=%b want 1", got); end
    endtask

    task automatic test_addr_withhold();
        obs_t o;
        logic got = 1'b0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, o);
            checks++; if (o.req !== 1'b1 || o.addr !== RESET_PC) begin errors++; $display("FAIL hold_req%0d: req=%b addr=%h want 1 %h", c, o.req, o.addr, RESET_PC); end
        end
        tick(1'b1, 32'h1c000200, 1'b0, 1'b0, 1'b1, o);
        tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, o);
        checks++; if (o.req !== 1'b1 || o.addr !== 32'h1c000200) begin errors++; $display("FAIL hold_switch: req=%b addr=%h want 1 1c000200", o.req, o.addr); end
        checks++; if (fire_q.size() !== 1 || fire_q[0] !== 32'h1c000200) begin errors++; $display("FAIL hold_accepted: fires=%0d want single fetch of 1c000200", fire_q.size()); end
        for (int c = 0; c < 40 && !got; c++) begin
            tick(1'b0, 32'd0, 1'b1, pend, 1'b1, o);
            if (o.del) begin
                got = 1'b1;
                checks++; if (o.pc !== 32'h1c000200) begin errors++; $display("FAIL hold_deliver: pc=%h want 1c000200", o.pc); end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL hold_timeout: delivered=%b want 1", got); end
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        logic got = 1'b0;
        do_reset();
        tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, o);
        tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, o);
        do_reset();
        tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, o);
        tick(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, o);
        tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, o);
        checks++; if (o.vld !== 1'b0) begin errors++; $display("FAIL late_dataok: valid=%b want 0", o.vld); end
        for (int c = 0; c < 40 && !got; c++) begin
            tick(1'b0, 32'd0, 1'b1, pend, 1'b1, o);
            if (o.del) begin
                got = 1'b1;
                checks++; if (o.pc !== RESET_PC || o.inst !== inst_of(RESET_PC)) begin errors++; $display("FAIL late_first: pc=%h inst=%h want %h %h", o.pc, o.inst, RESET_PC, inst_of(RESET_PC)); end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL late_timeout: delivered=%b want 1", got); end
        checks++; if (fire_q.size() == 0 || fire_q[0] !== RESET_PC) begin errors++; $display("FAIL late_fetch: fires=%0d want first fetch %h", fire_q.size(), RESET_PC); end
    endtask

    task automatic test_wrap();
        obs_t o;
        int   n_del = 0;
        logic seen_zero = 1'b0;
        do_reset();
        tick(1'b1, 32'hfffffff8, 1'b0, 1'b0, 1'b1, o);
        for (int c = 0; c < 60 && n_del < 4; c++) begin
            tick(1'b0, 32'd0, 1'b1, pend, 1'b1, o);
            if (o.del) begin
                n_del++;
                if (o.pc == 32'd0) seen_zero = 1'b1;
                checks++; if (o.pc !== o.epc || o.inst !== inst_of(o.epc)) begin errors++; $display("FAIL wrap_stream: pc=%h want %h", o.pc, o.epc); end
            end
        end
        checks++; if (!seen_zero) begin errors++; $display("FAIL wrap_zero: pc 0 delivered=%b want 1 (%0d deliveries)", seen_zero, n_del); end
    endtask

    task automatic test_random();
        obs_t        o;
        logic        br;
        logic [31:0] tgt;
        int          n_del = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            br  = ($urandom_range(0, 99) < 6);
            tgt = ($urandom_range(0, 9) == 0) ? 32'hfffffff0 : RESET_PC + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            tick(br, tgt, $urandom_range(0, 99) < 60, pend && ($urandom_range(0, 99) < 50),
                 $urandom_range(0, 99) < 70, o);
            if (br) begin
                checks++; if (o.vld !== 1'b0) begin errors++; $display("FAIL rand_br_valid: cycle %0d got %b want 0", c, o.vld); end
            end
            if (o.del) begin
                n_del++;
                checks++; if (o.pc !== o.epc || o.inst !== inst_of(o.epc)) begin errors++; $display("FAIL rand_stream: cycle %0d pc=%h inst=%h want pc=%h inst=%h", c, o.pc, o.inst, o.epc, inst_of(o.epc)); end
            end
            if (o.req) begin
                checks++; if (o.addr[1:0] !== 2'b00) begin errors++; $display("FAIL rand_align: addr=%h want word aligned", o.addr); end
            end
            if (o.fire) begin
                checks++; if (o.overlap !== 1'b0) begin errors++; $display("FAIL rand_outstanding: second request accepted at cycle %0d", c); end
            end
        end
        checks++; if (n_del < 100) begin errors++; $display("FAIL rand_progress: got %0d deliveries want >=100", n_del); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_outstanding();
        test_stall();
        test_br_flush();
        test_addr_withhold();
        test_reset_mid_wait();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
